pcie_dllp_tx_arbiter: RTL
=========================

Name: pcie_dllp_tx_arbiter

Overview:
Parametrised, packet-atomic arbiter that merges S_COUNT DLLP-producing AXI-Stream sources (flow-control init, Ack/Nak, UpdateFC, PM) into one registered stream toward the PHY. It sits between the datalink-layer DLLP generators and the PHY DLLP input. It supersedes the fixed two-input mux with selectable fixed-priority or round-robin arbitration, starvation promotion, link gating and per-source grant statistics.

Parameters:
DATA_WIDTH, 32, data bus width in bits
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
USER_WIDTH, 3, tuser width
S_COUNT, 4, number of source ports (2..8)
ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round robin
STARVE_LIMIT, 8, consecutive lost arbitrations before forced grant (1..255)
CNT_WIDTH, 16, width of each per-source saturating grant counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
link_up_i  in  1  new packets granted only while high
s_axis_tdata  in  S_COUNT*DATA_WIDTH  source data, source i at slice i
s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  source keep
s_axis_tvalid  in  S_COUNT  source valid
s_axis_tlast  in  S_COUNT  source last
s_axis_tuser  in  S_COUNT*USER_WIDTH  source user
s_axis_tready  out  S_COUNT  source ready
m_axis_tdata  out  DATA_WIDTH  merged data
m_axis_tkeep  out  KEEP_WIDTH  merged keep
m_axis_tvalid  out  1  merged valid
m_axis_tlast  out  1  merged last
m_axis_tuser  out  USER_WIDTH  merged user
m_axis_tready  in  1  PHY ready
grant_o  out  S_COUNT  one-hot active grant, zero when idle
grant_cnt_o  out  S_COUNT*CNT_WIDTH  per-source packet grant counters
clr_cnt_i  in  1  synchronous clear of all grant counters

Behaviour:
- Reset (async, rst_ni low): state IDLE, grant_o=0, m_axis_tvalid=0, tdata/tkeep/tuser/tlast=0, s_axis_tready=0, RR pointer=0, starve counters=0, grant counters=0.
- States: IDLE, XFER.
- IDLE: when link_up_i=1 and any s_axis_tvalid is set, pick a winner and latch grant_o; go to XFER next cycle. No beat is accepted in IDLE.
- Winner selection, in priority order:
  (a) lowest-index valid source whose starve counter ≥ STARVE_LIMIT;
  (b) ARB_MODE=0: lowest-index valid source;
  (c) ARB_MODE=1: first valid source at or after the RR pointer, wrapping modulo S_COUNT.
- XFER:
  - s_axis_tready[g] = m_axis_tready | ~m_axis_tvalid; all other readies are 0.
  - Output is a single register stage; an accepted source beat appears on m_axis one cycle later.
  - m_axis_tvalid holds, with stable data, until m_axis_tready.
  - On acceptance of the source beat with tlast=1, return to IDLE; grant_o clears the same edge.
  - Minimum one idle arbitration cycle between packets; the output register may still drain during IDLE.
- Packets are atomic. Deasserting link_up_i mid-packet does not truncate the packet; only new grants are blocked.
- On each grant to source g:
  - starve counter of g clears;
  - every other source valid at that arbitration cycle increments its starve counter, saturating at 255;
  - RR pointer = (g+1) mod S_COUNT;
  - grant_cnt[g] increments, saturating at all-ones.
- clr_cnt_i clears all grant counters. If it coincides with a grant, the clear wins (counter = 0).
- Only the granted source's tvalid is observed during XFER. Other sources may raise or drop valid freely without effect.
- tkeep/tuser pass through unmodified; no CRC or framing is added.

Decomposition:
- pcie_datalink_pkg gains:
  - typedef enum dllp_arb_state_e {IDLE, XFER};
  - localparams ARB_FIXED=0, ARB_RR=1.
- One combinational sub-module, pcie_dllp_arb_select, takes valid, starved mask, RR pointer and mode, and returns the one-hot winner. It is reused by the future TLP/DLLP merge.

Test Plan:
- S_COUNT=4, ARB_MODE=0, sources 1 and 3 each send a 2-beat packet at once -> source 1 packet fully precedes source 3; grant_o=0010 then 1000; grant_cnt = {1,0,1,0} for sources {3,2,1,0}.
- ARB_MODE=1, all 4 sources continuously valid, 8 packets -> grant order 0,1,2,3,0,1,2,3; each grant_cnt=2.
- ARB_MODE=0, STARVE_LIMIT=3, source 0 always valid, source 2 valid -> after source 0 wins 3 times, the 4th grant goes to source 2; its starve counter then resets.
- m_axis_tready held low 5 cycles mid-packet -> m_axis_tdata stable, s_axis_tready[g]=0, no beat lost or duplicated; byte-for-byte compare against the source.
- link_up_i drops on beat 2 of a 4-beat packet -> all 4 beats emitted with tlast on beat 4; no further grant until link_up_i=1.
- rst_ni asserted mid-XFER -> m_axis_tvalid=0 and grant_o=0 immediately (asynchronously); after release, the first arbitration starts from pointer 0.

Source files
------------

// File: rtl/pcie_datalink_pkg.sv
// Shared datalink-layer types: DLLP arbiter state encoding and arbitration modes.
package pcie_datalink_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } dllp_arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/pcie_dllp_arb_select.sv
// Combinational winner pick: starved sources first (lowest index), then
// fixed priority or round robin starting at ptr. Returns a one-hot grant.
module pcie_dllp_arb_select #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [N-1:0]  starved,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant
);

  logic [N-1:0] hit, cand;
  int           base;
  logic         found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    hit   = valid & starved;
    // A starved source overrides the rotation, so search from index 0.
    cand  = (|hit) ? hit : valid;
    base  = (|hit || !mode) ? 0 : int'(ptr);
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (base + j) % N;
      if (!found && cand[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_dllp_tx_arbiter.sv
// Packet-atomic DLLP source merge toward the PHY with starvation promotion,
// link gating, a single output register stage and per-source grant counters.
module pcie_dllp_tx_arbiter
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 3,
  parameter int S_COUNT      = 4,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          link_up_i,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [S_COUNT-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic [S_COUNT-1:0]            grant_o,
  output logic [S_COUNT*CNT_WIDTH-1:0]  grant_cnt_o,
  input  logic                          clr_cnt_i
);

  localparam int   IW      = $clog2(S_COUNT);
  localparam logic MODE_RR = (ARB_MODE != ARB_FIXED);

  dllp_arb_state_e        state, state_nxt;
  logic [S_COUNT-1:0]     grant, win, starved;
  logic [IW-1:0]          rr_ptr, gidx, widx;
  logic [7:0]             starve_cnt [S_COUNT];
  logic [CNT_WIDTH-1:0]   grant_cnt  [S_COUNT];
  logic                   arb_go, beat_rdy, acc, acc_last;

  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      starved[i] = (starve_cnt[i] >= 8'(STARVE_LIMIT));
      grant_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = grant_cnt[i];
    end
  end

  pcie_dllp_arb_select #(.N(S_COUNT)) u_sel (
    .valid   (s_axis_tvalid),
    .starved (starved),
    .ptr     (rr_ptr),
    .mode    (MODE_RR),
    .grant   (win)
  );

  always_comb begin
    gidx = '0;
    widx = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant[i]) gidx = IW'(i);
      if (win[i])   widx = IW'(i);
    end
  end

  assign arb_go   = (state == IDLE) && link_up_i && (|s_axis_tvalid);
  assign beat_rdy = m_axis_tready | ~m_axis_tvalid;
  assign acc      = (state == XFER) && s_axis_tvalid[gidx] && beat_rdy;
  assign acc_last = acc && s_axis_tlast[gidx];
  assign grant_o  = grant;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    case (state)
      IDLE: if (arb_go) state_nxt = XFER;
      XFER: begin
        s_axis_tready[gidx] = beat_rdy;
        if (acc_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: loads on accept, otherwise drains when the PHY takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (acc) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep  <= s_axis_tkeep[int'(gidx)*KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tuser  <= s_axis_tuser[int'(gidx)*USER_WIDTH +: USER_WIDTH];
      m_axis_tlast  <= s_axis_tlast[gidx];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else if (arb_go) begin
      grant  <= win;
      rr_ptr <= IW'((int'(widx) + 1) % S_COUNT);
    end else if (acc_last) begin
      grant  <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < S_COUNT; i++) begin
        starve_cnt[i] <= '0;
        grant_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < S_COUNT; i++) begin
        if (arb_go) begin
          if (win[i])                                  starve_cnt[i] <= '0;
          else if (s_axis_tvalid[i] && !(&starve_cnt[i])) starve_cnt[i] <= starve_cnt[i] + 8'd1;
        end
        if (clr_cnt_i)                                  grant_cnt[i] <= '0;
        else if (arb_go && win[i] && !(&grant_cnt[i]))  grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
    end
  end

endmodule
